// File: rtl/servo_jog_pwm.sv
// Per-channel PWM servo driver with jog buttons, pose recording and looped playback.
// Latency: jog edge to live duty 1 cycle, applied at next period wrap; backpressure: none, inputs are levels.
module servo_jog_pwm #(
    parameter int CH        = 2,
    parameter int W         = 6,
    parameter int DEPTH     = 16,
    parameter int STEP      = 1,
    parameter int DUTY_INIT = 2 ** (W - 1),
    parameter int PLAY_DIV  = 8
) (
    input  logic                         sysclk,
    input  logic                         Reset_Sw,
    input  logic [CH-1:0]                Inc,
    input  logic [CH-1:0]                Dec,
    input  logic                         Storage_Sw,
    output logic [CH-1:0]                Pulse,
    output logic [CH*W-1:0]              Duty_Out,
    output logic [$clog2(DEPTH+1)-1:0]   Rec_Count,
    output logic                         Full,
    output logic                         Playing
);
    localparam int             CW       = $clog2(DEPTH + 1);
    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [W-1:0]   DMAX     = '1;
    localparam logic [W-1:0]   DINIT    = W'(DUTY_INIT);
    localparam logic [W-1:0]   DSTEP    = W'(STEP);
    localparam logic [7:0]     DIV_LAST = 8'(PLAY_DIV - 1);

    typedef enum logic {ST_LIVE = 1'b0, ST_PLAY = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           cnt;
    logic                   wrap;
    logic [CH-1:0]          inc_q, dec_q, inc_ev, dec_ev;
    logic [CH-1:0][W-1:0]   live_q, live_d, applied, src;
    logic [CH-1:0][W-1:0]   pose_mem [DEPTH];
    logic [PW-1:0]          rd_ptr;
    logic [7:0]             div_q;
    logic                   changed, rec_we, rd_last, have_rec;

    assign wrap     = (cnt == DMAX);
    assign inc_ev   = Inc & ~inc_q;
    assign dec_ev   = Dec & ~dec_q;
    assign have_rec = (Rec_Count != '0);
    assign rd_last  = (CW'(rd_ptr) == Rec_Count - CW'(1));

    assign Duty_Out = applied;
    assign Full     = (Rec_Count == CW'(DEPTH));
    assign Playing  = (state_q == ST_PLAY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LIVE: if (Storage_Sw)  state_d = ST_PLAY;
            ST_PLAY: if (!Storage_Sw) state_d = ST_LIVE;
            default: state_d = ST_LIVE;
        endcase
    end

    // Opposing jogs in the same cycle cancel; saturation yields no change and so no record.
    always_comb begin
        live_d  = live_q;
        changed = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (state_q == ST_LIVE && (inc_ev[i] ^ dec_ev[i])) begin
                if (inc_ev[i])
                    live_d[i] = (live_q[i] > DMAX - DSTEP) ? DMAX : live_q[i] + DSTEP;
                else
                    live_d[i] = (live_q[i] < DSTEP) ? '0 : live_q[i] - DSTEP;
            end
            if (live_d[i] != live_q[i])
                changed = 1'b1;
        end
        rec_we = changed && !Full;
    end

    always_comb begin
        src = live_q;
        if (state_q == ST_PLAY && have_rec)
            src = pose_mem[rd_ptr];
    end

    always_ff @(posedge sysclk) begin
        if (Reset_Sw) begin
            state_q   <= ST_LIVE;
            cnt       <= '0;
            inc_q     <= '0;
            dec_q     <= '0;
            live_q    <= {CH{DINIT}};
            applied   <= {CH{DINIT}};
            Pulse     <= '0;
            Rec_Count <= '0;
            rd_ptr    <= '0;
            div_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt + W'(1);
            inc_q   <= Inc;
            dec_q   <= Dec;
            live_q  <= live_d;
            if (rec_we)
                Rec_Count <= Rec_Count + CW'(1);
            // Loading only at the wrap keeps every PWM period whole.
            if (wrap)
                applied <= src;
            for (int i = 0; i < CH; i++)
                Pulse[i] <= (cnt < applied[i]);
            if (state_q == ST_LIVE) begin
                rd_ptr <= '0;
                div_q  <= '0;
            end else if (wrap && have_rec) begin
                if (div_q == DIV_LAST) begin
                    div_q  <= '0;
                    rd_ptr <= rd_last ? '0 : rd_ptr + PW'(1);
                end else begin
                    div_q <= div_q + 8'd1;
                end
            end
        end
    end

    // Pose storage carries no reset; slots at or above Rec_Count are never read.
    always_ff @(posedge sysclk) begin
        if (!Reset_Sw && rec_we)
            pose_mem[Rec_Count[PW-1:0]] <= live_d;
    end

endmodule

// File: tb/tb_servo_jog_pwm.sv
// Bench for servo_jog_pwm: scoreboard of expected applied duty, compared at each period wrap.
module tb_servo_jog_pwm;
    localparam int CH = 2, W = 6, DEPTH = 4, STEP = 1, PLAY_DIV = 2;
    localparam int CW = $clog2(DEPTH + 1);

    logic            sysclk = 1'b0;
    logic            Reset_Sw, Storage_Sw;
    logic [CH-1:0]   Inc, Dec, Pulse;
    logic [CH*W-1:0] Duty_Out;
    logic [CW-1:0]   Rec_Count;
    logic            Full, Playing;

    int n_checks = 0;
    int n_pass   = 0;
    int tb_cnt   = 0;
    logic [CH*W-1:0] exp_q [$];

    servo_jog_pwm #(.CH(CH), .W(W), .DEPTH(DEPTH), .STEP(STEP), .PLAY_DIV(PLAY_DIV)) dut (
        .sysclk(sysclk), .Reset_Sw(Reset_Sw), .Inc(Inc), .Dec(Dec), .Storage_Sw(Storage_Sw),
        .Pulse(Pulse), .Duty_Out(Duty_Out), .Rec_Count(Rec_Count), .Full(Full), .Playing(Playing)
    );

    always #5 sysclk = ~sysclk;

    // Reference PWM phase: 0 after a reset edge, wraps every 64 cycles.
    always @(posedge sysclk) tb_cnt <= Reset_Sw ? 0 : (tb_cnt + 1) % 64;

    function automatic logic [CH*W-1:0] pk(input int d1, input int d0);
        return {W'(d1), W'(d0)};
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic to_boundary();
        int n = 0;
        do begin
            tick();
            n++;
        end while (tb_cnt != 0 && n < 70);
    endtask

    task automatic jog(input int ch, input bit up);
        if (up) Inc[ch] = 1'b1;
        else    Dec[ch] = 1'b1;
        tick(); tick();
        Inc = '0;
        Dec = '0;
        tick(); tick();
    endtask

    task automatic count_high(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        repeat (64) begin
            tick();
            if (Pulse[0] === 1'b1) c0++;
            if (Pulse[1] === 1'b1) c1++;
        end
    endtask

    task automatic do_reset();
        Reset_Sw = 1'b1;
        tick();
        Reset_Sw = 1'b0;
    endtask

    task automatic test_reset();
        Reset_Sw = 1'b1; Storage_Sw = 1'b0; Inc = '0; Dec = '0;
        tick(); tick();
        n_checks++; if (Pulse !== 2'b00) $display("FAIL reset_pulse: got %b want 00", Pulse); else n_pass++;
        n_checks++; if (Duty_Out !== pk(32, 32)) $display("FAIL reset_duty: got %h want %h", Duty_Out, pk(32, 32)); else n_pass++;
        n_checks++; if (Rec_Count !== 3'd0) $display("FAIL reset_count: got %0d want 0", Rec_Count); else n_pass++;
        n_checks++; if (Full !== 1'b0) $display("FAIL reset_full: got %b want 0", Full); else n_pass++;
        n_checks++; if (Playing !== 1'b0) $display("FAIL reset_playing: got %b want 0", Playing); else n_pass++;
        Reset_Sw = 1'b0;
    endtask

    task automatic test_idle_pwm();
        int c0, c1;
        to_boundary();
        for (int p = 0; p < 2; p++) begin
            count_high(c0, c1);
            n_checks++; if (c0 !== 32) $display("FAIL idle_pulse0_p%0d: high %0d want 32", p, c0); else n_pass++;
            n_checks++; if (c1 !== 32) $display("FAIL idle_pulse1_p%0d: high %0d want 32", p, c1); else n_pass++;
        end
        n_checks++; if (Duty_Out !== pk(32, 32)) $display("FAIL idle_duty: got %h want %h", Duty_Out, pk(32, 32)); else n_pass++;
        n_checks++; if (Rec_Count !== 3'd0) $display("FAIL idle_count: got %0d want 0", Rec_Count); else n_pass++;
    endtask

    task automatic test_jog_record();
        logic [CH*W-1:0] exp;
        to_boundary();
        repeat (5) jog(0, 1'b1);
        exp_q.push_back(pk(32, 37));
        n_checks++; if (Rec_Count !== 3'd4) $display("FAIL jog_count: got %0d want 4", Rec_Count); else n_pass++;
        n_checks++; if (Full !== 1'b1) $display("FAIL jog_full: got %b want 1", Full); else n_pass++;
        while (tb_cnt != 63) tick();
        n_checks++; if (Duty_Out !== pk(32, 32)) $display("FAIL jog_before_wrap: got %h want %h", Duty_Out, pk(32, 32)); else n_pass++;
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (Duty_Out !== exp) $display("FAIL jog_after_wrap: got %h want %h", Duty_Out, exp); else n_pass++;
    endtask

    task automatic test_saturate();
        logic [CH*W-1:0] exp;
        int c0, c1;
        repeat (32) jog(1, 1'b1);
        exp_q.push_back(pk(63, 37));
        to_boundary();
        exp = exp_q.pop_front();
        n_checks++; if (Duty_Out !== exp) $display("FAIL sat_high: got %h want %h", Duty_Out, exp); else n_pass++;
        n_checks++; if (Rec_Count !== 3'd4) $display("FAIL sat_count: got %0d want 4", Rec_Count); else n_pass++;
        repeat (64) jog(1, 1'b0);
        exp_q.push_back(pk(0, 37));
        to_boundary();
        exp = exp_q.pop_front();
        n_checks++; if (Duty_Out !== exp) $display("FAIL sat_low: got %h want %h", Duty_Out, exp); else n_pass++;
        count_high(c0, c1);
        n_checks++; if (c1 !== 0) $display("FAIL sat_pulse1_zero: high %0d want 0", c1); else n_pass++;
        n_checks++; if (c0 !== 37) $display("FAIL sat_pulse0: high %0d want 37", c0); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [CH*W-1:0] exp;
        do_reset();
        to_boundary();
        Inc[0] = 1'b1;
        Dec[0] = 1'b1;
        tick(); tick();
        Inc = '0;
        Dec = '0;
        tick(); tick();
        exp_q.push_back(pk(32, 32));
        n_checks++; if (Rec_Count !== 3'd0) $display("FAIL simul_count: got %0d want 0", Rec_Count); else n_pass++;
        to_boundary();
        exp = exp_q.pop_front();
        n_checks++; if (Duty_Out !== exp) $display("FAIL simul_duty: got %h want %h", Duty_Out, exp); else n_pass++;
    endtask

    task automatic test_playback();
        logic [CH*W-1:0] exp;
        jog(0, 1'b1);
        jog(1, 1'b1);
        jog(0, 1'b0);
        n_checks++; if (Rec_Count !== 3'd3) $display("FAIL play_rec_count: got %0d want 3", Rec_Count); else n_pass++;
        n_checks++; if (Full !== 1'b0) $display("FAIL play_rec_full: got %b want 0", Full); else n_pass++;
        to_boundary();
        Storage_Sw = 1'b1;
        tick();
        n_checks++; if (Playing !== 1'b1) $display("FAIL play_enter: got %b want 1", Playing); else n_pass++;
        exp_q.push_back(pk(32, 33)); exp_q.push_back(pk(32, 33));
        exp_q.push_back(pk(33, 33)); exp_q.push_back(pk(33, 33));
        exp_q.push_back(pk(33, 32)); exp_q.push_back(pk(33, 32));
        exp_q.push_back(pk(32, 33));
        for (int k = 0; k < 7; k++) begin
            to_boundary();
            exp = exp_q.pop_front();
            n_checks++; if (Duty_Out !== exp) $display("FAIL play_step%0d: got %h want %h", k, Duty_Out, exp); else n_pass++;
            if (k == 0) jog(0, 1'b1);
        end
        Storage_Sw = 1'b0;
        tick();
        n_checks++; if (Playing !== 1'b0) $display("FAIL play_exit: got %b want 0", Playing); else n_pass++;
        exp_q.push_back(pk(33, 32));
        to_boundary();
        exp = exp_q.pop_front();
        n_checks++; if (Duty_Out !== exp) $display("FAIL play_live_back: got %h want %h", Duty_Out, exp); else n_pass++;
        n_checks++; if (Rec_Count !== 3'd3) $display("FAIL play_count_kept: got %0d want 3", Rec_Count); else n_pass++;
        jog(1, 1'b1);
        n_checks++; if (Rec_Count !== 3'd4) $display("FAIL play_append: got %0d want 4", Rec_Count); else n_pass++;
        n_checks++; if (Full !== 1'b1) $display("FAIL play_append_full: got %b want 1", Full); else n_pass++;
    endtask

    task automatic test_reset_in_play();
        logic [CH*W-1:0] exp;
        Storage_Sw = 1'b1;
        to_boundary();
        to_boundary();
        repeat (10) tick();
        Reset_Sw = 1'b1;
        Storage_Sw = 1'b0;
        tick();
        Reset_Sw = 1'b0;
        n_checks++; if (Playing !== 1'b0) $display("FAIL rst_play_playing: got %b want 0", Playing); else n_pass++;
        n_checks++; if (Rec_Count !== 3'd0) $display("FAIL rst_play_count: got %0d want 0", Rec_Count); else n_pass++;
        n_checks++; if (Full !== 1'b0) $display("FAIL rst_play_full: got %b want 0", Full); else n_pass++;
        n_checks++; if (Pulse !== 2'b00) $display("FAIL rst_play_pulse: got %b want 00", Pulse); else n_pass++;
        exp_q.push_back(pk(32, 32));
        to_boundary();
        exp = exp_q.pop_front();
        n_checks++; if (Duty_Out !== exp) $display("FAIL rst_play_duty: got %h want %h", Duty_Out, exp); else n_pass++;

        jog(0, 1'b1);
        Storage_Sw = 1'b1;
        exp_q.push_back(pk(32, 33));
        to_boundary();
        exp = exp_q.pop_front();
        n_checks++; if (Duty_Out !== exp) $display("FAIL rst_hold_pre: got %h want %h", Duty_Out, exp); else n_pass++;
        repeat (5) tick();
        Reset_Sw = 1'b1;
        tick();
        Reset_Sw = 1'b0;
        n_checks++; if (Playing !== 1'b0) $display("FAIL rst_hold_playing0: got %b want 0", Playing); else n_pass++;
        tick();
        n_checks++; if (Playing !== 1'b1) $display("FAIL rst_hold_reenter: got %b want 1", Playing); else n_pass++;
        n_checks++; if (Rec_Count !== 3'd0) $display("FAIL rst_hold_count: got %0d want 0", Rec_Count); else n_pass++;
        exp_q.push_back(pk(32, 32));
        to_boundary();
        exp = exp_q.pop_front();
        n_checks++; if (Duty_Out !== exp) $display("FAIL rst_hold_live_src: got %h want %h", Duty_Out, exp); else n_pass++;
        Storage_Sw = 1'b0;
        tick();
    endtask

    initial begin
        Reset_Sw   = 1'b1;
        Storage_Sw = 1'b0;
        Inc        = '0;
        Dec        = '0;
        test_reset();
        test_idle_pwm();
        test_jog_record();
        test_saturate();
        test_simultaneous();
        test_playback();
        test_reset_in_play();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
